pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Parametrised program-counter unit: holds the PC, computes the next PC and drives instruction fetch.
//   Next-PC sources are sequential increment, branch and jump.
//   Adds stall hold, a req/ack fetch handshake and capture of redirects that arrive during an outstanding fetch.
//   Sits between the control unit / branch logic and the instruction memory.
// PARAMETERS
//   WIDTH         32            PC / address width in bits
//   RESET_VECTOR  32'h0000_0000 PC value loaded on reset
//   INC           4             sequential increment in bytes; power of two, >= 1
//   TRAP_VECTOR   32'h0000_0080 redirect address for misaligned targets (PC_MISALIGN_TRAP_EN only)
// PORTS
//   clock          in   1      rising-edge clock
//   Reset_n        in   1      asynchronous, active-low reset
//   stall          in   1      pipeline stall; the PC must not advance while high
//   branch_taken   in   1      branch redirect request (single-cycle qualifier)
//   branch_target  in   WIDTH  branch target address
//   jump           in   1      jump redirect request; takes priority over branch_taken
//   jump_target    in   WIDTH  jump target address
//   fetch_ack      in   1      instruction memory has accepted/returned fetch_addr
//   fetch_req      out  1      fetch request to instruction memory
//   fetch_addr     out  WIDTH  fetch address; always equal to PC_out
//   PC_out         out  WIDTH  current PC
//   PC_plus        out  WIDTH  PC_out + INC, combinational, modulo 2^WIDTH
//   misalign       out  1      one-cycle pulse when a misaligned redirect is trapped
// BEHAVIOUR
//   - Reset (Reset_n low, asynchronous):
//     PC_out=RESET_VECTOR, fetch_req=0, misalign=0, pending redirect cleared, state=BOOT.
//   - Deassertion is sampled on clock; reset asserted mid-fetch aborts the fetch immediately.
//   - States: BOOT, FETCH, HOLD.
//   - BOOT: fetch_req=0; moves to FETCH on the next clock edge unconditionally, giving one idle cycle after reset.
//   - FETCH: fetch_req=1.
//     - No fetch_ack: PC_out/fetch_addr held stable; redirects are captured (see below).
//     - fetch_ack & !stall: PC_out<=NEXT on the same edge; stay in FETCH, so back-to-back fetches issue every cycle.
//     - fetch_ack & stall: PC_out unchanged; go to HOLD.
//   - HOLD: fetch_req=0.
//     - stall low: PC_out<=NEXT; go to FETCH.
//     - stall high: stay in HOLD; redirects are captured.
//   - NEXT priority, highest first: jump ? jump_target; branch_taken ? branch_target;
//     pending valid ? pending_target; otherwise PC_out+INC.
//   - Increment wraps modulo 2^WIDTH: 'hFFFF_FFFC + 4 = 0.
//   - Pending redirect: 1-entry register.
//     - Loaded when jump|branch_taken is high in a cycle where PC_out does not update.
//     - Latest request overwrites; jump beats branch in the same cycle.
//     - Consumed and cleared on the next PC_out update.
//     - A same-cycle redirect at update time wins over pending, and pending is cleared.
//   - Stall has no effect in BOOT.
//   - stall and fetch_ack together in FETCH: the ack is honoured (the instruction is taken), but the PC is held.
//   - Misaligned target: any of the low log2(INC) bits nonzero; not checked when INC=1.
// CONFIGURATION
//   PC_MISALIGN_TRAP_EN defined:
//     - A misaligned selected target loads PC_out=TRAP_VECTOR.
//     - misalign=1 for exactly the cycle after that update.
//   PC_MISALIGN_TRAP_EN undefined:
//     - Low log2(INC) bits of the target are forced to 0.
//     - misalign is tied to 0 and TRAP_VECTOR is unused.
// TESTING
//   1 Reset low then high, fetch_ack tied 1 ->
//     PC_out=0, fetch_req=0 for 1 cycle; then PC_out = 0, 4, 8, 12 on consecutive cycles.
//   2 In FETCH at PC=0x10 with ack=0; branch_taken=1, target=0x40 for 1 cycle; ack=1 three cycles later ->
//     PC_out stays 0x10 until the ack, then becomes 0x40.
//   3 PC=0x20, ack=1, stall=1 for 3 cycles ->
//     fetch_req drops next cycle, PC_out=0x20 throughout; stall low -> PC_out=0x24, fetch_req=1.
//   4 jump=1 (target 0x100) and branch_taken=1 (target 0x200) in the same acked cycle ->
//     PC_out=0x100, pending stays empty.
//   5 PC=0xFFFF_FFFC, ack=1 -> PC_out=0x0 next cycle.
//     Reset_n pulsed low mid-cycle -> PC_out=0 before the next edge.
//   6 jump_target=0x102, ack=1 ->
//     with PC_MISALIGN_TRAP_EN: PC_out=0x80, misalign=1 for 1 cycle;
//     without PC_MISALIGN_TRAP_EN: PC_out=0x100, misalign=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter unit. It holds the PC, selects the next PC and drives
//   instruction fetch through a req/ack handshake.
//   Next-PC sources, highest priority first:
//     jump, branch, captured (pending) redirect, sequential increment.
//   A redirect that arrives while the PC cannot move goes into a one-entry
//   pending register. The next PC update consumes it.
//
// Parameters
//   WIDTH         PC / address width in bits
//   RESET_VECTOR  PC value loaded on reset
//   INC           sequential increment in bytes (power of two, >= 1)
//   TRAP_VECTOR   redirect address for misaligned targets
//                 (present only when PC_MISALIGN_TRAP_EN is defined)
//
// Build option
//   PC_MISALIGN_TRAP_EN  defined:   a misaligned redirect target loads TRAP_VECTOR
//                                   and pulses misalign for one cycle
//                        undefined: the low log2(INC) target bits are forced to 0
//                                   and misalign is tied low
//
// Ports
//   clock          in   rising-edge clock
//   Reset_n        in   asynchronous active-low reset
//   stall          in   pipeline stall; the PC does not advance while high
//   branch_taken   in   branch redirect request
//   branch_target  in   branch target address
//   jump           in   jump redirect request (beats branch_taken)
//   jump_target    in   jump target address
//   fetch_ack      in   instruction memory accepted fetch_addr
//   fetch_req      out  fetch request
//   fetch_addr     out  fetch address (== PC_out)
//   PC_out         out  current PC
//   PC_plus        out  PC_out + INC, modulo 2^WIDTH
//   misalign       out  one-cycle pulse after a trapped misaligned redirect
module pc_fetch_unit #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                 INC          = 4
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080)
`endif
) (
  input  logic             clock,
  input  logic             Reset_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             fetch_ack,
  output logic             fetch_req,
  output logic [WIDTH-1:0] fetch_addr,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] PC_plus,
  output logic             misalign
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  // With INC == 1 the mask is zero, so no alignment check takes place.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

  state_t           state, state_next;
  logic [WIDTH-1:0] pc_q, pc_next;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             pc_update;
  logic             redirect;
  logic [WIDTH-1:0] redirect_target;
  logic             target_is_redirect;
  logic [WIDTH-1:0] sel_target;

  assign PC_out     = pc_q;
  assign fetch_addr = pc_q;
  assign PC_plus    = pc_q + INC_W;
  assign fetch_req  = (state == FETCH);

  assign redirect        = jump | branch_taken;
  assign redirect_target = jump ? jump_target : branch_target;

  // Handshake FSM. pc_update marks every cycle in which the PC takes NEXT.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_next = state;
    pc_update  = 1'b0;
    unique case (state)
      BOOT:  state_next = FETCH;
      FETCH: begin
        if (fetch_ack) begin
          // The ack is honoured even under stall; only the PC is held.
          if (stall) state_next = HOLD;
          else       pc_update  = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_update  = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // Next-PC source selection. A live redirect beats the pending one.
  always_comb begin
    target_is_redirect = 1'b1;
    if (redirect)        sel_target = redirect_target;
    else if (pend_valid) sel_target = pend_target;
    else begin
      target_is_redirect = 1'b0;
      sel_target         = PC_plus;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic target_misaligned;
  logic misalign_q;

  assign target_misaligned = target_is_redirect && ((sel_target & ALIGN_MASK) != '0);
  assign pc_next           = target_misaligned ? TRAP_VECTOR : sel_target;
  assign misalign          = misalign_q;

  // The pulse lines up with the cycle that shows TRAP_VECTOR on PC_out.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) misalign_q <= 1'b0;
    else          misalign_q <= pc_update && target_misaligned;
  end
`else
  assign pc_next  = target_is_redirect ? (sel_target & ~ALIGN_MASK) : sel_target;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clock or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values, whatever order the statements run in.
    if (!Reset_n) begin
      state <= BOOT;
      pc_q  <= RESET_VECTOR;
    end else begin
      state <= state_next;
      if (pc_update) pc_q <= pc_next;
    end
  end

  // Pending redirect. It is captured only in cycles where the PC holds. The
  // latest request overwrites it, and any PC update clears it.
  always_ff @(posedge clock or negedge Reset_n) begin
    // NOTE: the target register is reset along with its valid bit. A valid
    // bit alone would suffice, but this keeps the contents deterministic.
    if (!Reset_n) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (pc_update) begin
      pend_valid  <= 1'b0;
    end else if (redirect) begin
      pend_valid  <= 1'b1;
      pend_target <= redirect_target;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit (default parameters).
// A table of per-cycle input records drives the DUT. Each record's expected
// post-edge outputs go into a scoreboard queue when the inputs are driven.
// They are popped and compared one time unit after the clock edge.
// Hand-written sequences cover the asynchronous reset and the boot idle cycle.
module tb_pc_fetch_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic             stall;
    logic             br;
    logic [WIDTH-1:0] bt;
    logic             jmp;
    logic [WIDTH-1:0] jt;
    logic             ack;
    logic [WIDTH-1:0] exp_pc;
    logic             exp_req;
    logic             exp_mis;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] pc;
    logic             req;
    logic             mis;
  } exp_t;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [WIDTH-1:0] MIS_PC   = 32'h80;
  localparam logic [WIDTH-1:0] MIS_NEXT = 32'h84;
  localparam logic             MIS_BIT  = 1'b1;
`else
  localparam logic [WIDTH-1:0] MIS_PC   = 32'h100;
  localparam logic [WIDTH-1:0] MIS_NEXT = 32'h104;
  localparam logic             MIS_BIT  = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             Reset_n;
  logic             stall, branch_taken, jump, fetch_ack;
  logic [WIDTH-1:0] branch_target, jump_target;
  logic             fetch_req, misalign;
  logic [WIDTH-1:0] fetch_addr, PC_out, PC_plus;

  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  exp_t sb[$];

  pc_fetch_unit dut (
    .clock         (clock),
    .Reset_n       (Reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .fetch_ack     (fetch_ack),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .PC_out        (PC_out),
    .PC_plus       (PC_plus),
    .misalign      (misalign)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic br, input logic [WIDTH-1:0] bt,
                              input logic jmp, input logic [WIDTH-1:0] jt, input logic ack,
                              input logic [WIDTH-1:0] pc, input logic req, input logic mis);
    vec_t v;
    v.stall = st;  v.br = br;   v.bt = bt;  v.jmp = jmp; v.jt = jt;
    v.ack = ack;   v.exp_pc = pc; v.exp_req = req; v.exp_mis = mis;
    return v;
  endfunction

  task automatic drive_idle();
    stall = 0; branch_taken = 0; jump = 0; fetch_ack = 0;
    branch_target = '0; jump_target = '0;
  endtask

  initial begin
    exp_t e;
    // Arguments: stall, br, bt, jmp, jt, ack | expected pc, req, misalign after the edge
    // Sequential fetch from reset
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h0,   1, 0)); // BOOT -> FETCH
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h4,   1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h8,   1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'hC,   1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h10,  1, 0));
    // Branch during outstanding fetch is held until the ack
    vecs.push_back(mk(0,1,32'h40,    0,0,            0, 32'h10,  1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            0, 32'h10,  1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            0, 32'h10,  1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h40,  1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h44,  1, 0)); // pending cleared
    // Stall with ack -> HOLD, then release
    vecs.push_back(mk(0,0,0,         1,32'h20,       1, 32'h20,  1, 0));
    vecs.push_back(mk(1,0,0,         0,0,            1, 32'h20,  0, 0));
    vecs.push_back(mk(1,0,0,         0,0,            1, 32'h20,  0, 0));
    vecs.push_back(mk(1,0,0,         0,0,            1, 32'h20,  0, 0));
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h24,  1, 0));
    // Jump beats branch in the same acked cycle; nothing left pending
    vecs.push_back(mk(0,1,32'h200,   1,32'h100,      1, 32'h100, 1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h104, 1, 0));
    // Redirect captured in HOLD
    vecs.push_back(mk(1,0,0,         0,0,            1, 32'h104, 0, 0));
    vecs.push_back(mk(1,1,32'h300,   0,0,            0, 32'h104, 0, 0));
    vecs.push_back(mk(0,0,0,         0,0,            0, 32'h300, 1, 0));
    // Live redirect at update time beats pending, and pending is dropped
    vecs.push_back(mk(0,1,32'h400,   0,0,            0, 32'h300, 1, 0));
    vecs.push_back(mk(0,0,0,         1,32'h500,      1, 32'h500, 1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h504, 1, 0));
    // Stall without ack stays in FETCH
    vecs.push_back(mk(1,0,0,         0,0,            0, 32'h504, 1, 0));
    // Wrap-around
    vecs.push_back(mk(0,0,0,         1,32'hFFFF_FFFC,1, 32'hFFFF_FFFC, 1, 0));
    vecs.push_back(mk(0,0,0,         0,0,            1, 32'h0,   1, 0));
    // Misaligned jump target
    vecs.push_back(mk(0,0,0,         1,32'h102,      1, MIS_PC,  1, MIS_BIT));
    vecs.push_back(mk(0,0,0,         0,0,            1, MIS_NEXT,1, 0));

    // Reset state
    drive_idle();
    fetch_ack = 1;
    Reset_n   = 0;
    repeat (2) @(posedge clock);
    #1;
    check("reset PC_out",    PC_out,    32'h0);
    check("reset fetch_req", {31'b0, fetch_req}, 32'h0);
    check("reset misalign",  {31'b0, misalign},  32'h0);
    @(negedge clock);
    Reset_n = 1;
    #1;
    check("boot idle fetch_req", {31'b0, fetch_req}, 32'h0);

    foreach (vecs[i]) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      jump  = vecs[i].jmp;   jump_target  = vecs[i].jt; fetch_ack     = vecs[i].ack;
      e.pc = vecs[i].exp_pc; e.req = vecs[i].exp_req; e.mis = vecs[i].exp_mis;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d PC_out", i),     PC_out,              e.pc);
      check($sformatf("v%0d fetch_addr", i), fetch_addr,          e.pc);
      check($sformatf("v%0d PC_plus", i),    PC_plus,             e.pc + 32'd4);
      check($sformatf("v%0d fetch_req", i),  {31'b0, fetch_req},  {31'b0, e.req});
      check($sformatf("v%0d misalign", i),   {31'b0, misalign},   {31'b0, e.mis});
    end

    // Asynchronous reset mid-cycle: the PC returns to the reset vector before the next edge
    drive_idle();
    fetch_ack = 1;
    #2;
    Reset_n = 0;
    #1;
    check("async reset PC_out",    PC_out,             32'h0);
    check("async reset fetch_req", {31'b0, fetch_req}, 32'h0);
    @(negedge clock);
    Reset_n = 1;
    @(posedge clock);
    #1;
    check("post-reset FETCH req",  {31'b0, fetch_req}, 32'h1);
    check("post-reset PC_out",     PC_out,             32'h0);
    @(posedge clock);
    #1;
    check("post-reset first inc",  PC_out,             32'h4);

    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
